// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the IF/LS memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_ADDRSIZE = 12;
    localparam int DEF_TIMEOUT  = 255;

    // Width of the ISSUE-state watchdog counter; TIMEOUT must fit in it.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDRSIZE = DEF_ADDRSIZE
) ();

    logic                if_req;
    logic [ADDRSIZE-1:0] if_addr;
    logic                if_gnt;
    logic                if_rvalid;
    logic [WIDTH-1:0]    if_rdata;
    logic                if_err;

    logic                ls_req;
    logic                ls_we;
    logic [ADDRSIZE-1:0] ls_addr;
    logic [WIDTH-1:0]    ls_wdata;
    logic                ls_gnt;
    logic                ls_rvalid;
    logic [WIDTH-1:0]    ls_rdata;
    logic                ls_err;

    logic                mem_req;
    logic                mem_we;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic                mem_ready;
    logic [WIDTH-1:0]    mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Index 0 is IF, index 1 is LS.
// After reset the pointer favours index 0; after every accepted grant it
// moves to the requester that did not win.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    // Pick a single winner: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        if (en) begin
            if (req == 2'b01) begin
                gnt = 2'b01;
            end else if (req == 2'b10) begin
                gnt = 2'b10;
            end else if (req == 2'b11) begin
                gnt = ptr_q ? 2'b10 : 2'b01;
            end
        end
        if (accept && (gnt != 2'b00)) begin
            ptr_d = gnt[0];
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the instruction-fetch (IF) and load/store (LS)
// ports. One access is in flight at a time: IDLE grants, ISSUE holds the
// access on the memory bus until mem_ready or the watchdog expires, and RESP
// returns a one-cycle response to the owning requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDRSIZE = DEF_ADDRSIZE,
    // ISSUE cycles allowed before abort; must lie in 1..255.
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W:0] TIMEOUT_CNT = (CNT_W+1)'(TIMEOUT);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDRSIZE-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                in_idle;
    logic                in_issue;
    logic                resp_if;
    logic                resp_ls;
    logic                cnt_expired;
    logic [1:0]          arb_req;
    logic [1:0]          arb_gnt;

    assign in_idle  = (state_q == IDLE);
    assign in_issue = (state_q == ISSUE);
    assign resp_if  = (state_q == RESP) && (owner_q == OWN_IF);
    assign resp_ls  = (state_q == RESP) && (owner_q == OWN_LS);
    assign arb_req  = {bus.ls_req, bus.if_req};

    // The count after this cycle would reach TIMEOUT.
    assign cnt_expired = (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) == TIMEOUT_CNT);

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (in_idle),
        .req    (arb_req),
        .accept (in_idle),
        .gnt    (arb_gnt)
    );

    assign bus.if_gnt    = arb_gnt[0];
    assign bus.ls_gnt    = arb_gnt[1];

    assign bus.mem_req   = in_issue;
    assign bus.mem_we    = in_issue & we_q;
    assign bus.mem_addr  = in_issue ? addr_q : '0;
    assign bus.mem_wdata = in_issue ? wdata_q : '0;

    assign bus.if_rvalid = resp_if;
    assign bus.if_rdata  = resp_if ? rdata_q : '0;
    assign bus.if_err    = resp_if & err_q;
    assign bus.ls_rvalid = resp_ls;
    assign bus.ls_rdata  = resp_ls ? rdata_q : '0;
    assign bus.ls_err    = resp_ls & err_q;

    // Next-state logic: latch the granted access, wait for the memory or the
    // watchdog, then hand the result back for a single cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    owner_d = arb_gnt[1] ? OWN_LS : OWN_IF;
                    we_d    = arb_gnt[1] & bus.ls_we;
                    addr_d  = arb_gnt[1] ? bus.ls_addr : bus.if_addr;
                    wdata_d = arb_gnt[1] ? bus.ls_wdata : '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    rdata_d = we_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_expired) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured access, response and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
